// File: rtl/dma_writer.sv
// -----------------------------------------------------------------------------
// dma_writer
//   Write-direction DMA for the fully-connected datapath. On a start request it
//   snapshots a parallel result buffer. It then streams the words, one per
//   accepted beat, into memory at consecutive addresses. Addresses wrap modulo
//   2^MEM_ADDRESS_WIDTH. The memory side can stall the stream with a
//   valid/ready handshake.
//
//   Optional feature (macro DMA_WRITER_STRIDE_EN): adds input i_stride. Beat k
//   is then written to base + k*stride. This uses an accumulating address
//   register. When the macro is undefined the stride is fixed at 1.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   i_write      start request, sampled while idle
//   i_address    base memory address
//   i_count      number of words to write (clamped to BUFFER_SIZE)
//   i_buffer     flattened source buffer, word k = [k*MEM_WIDTH +: MEM_WIDTH]
//   i_stride     address step per beat (only with DMA_WRITER_STRIDE_EN)
//   i_mem_ready  memory accepts the presented beat
//   o_mem_addr   write address
//   o_mem_data   write data
//   o_mem_write  write beat valid
//   o_busy       transfer in progress (beats pending)
//   o_done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module dma_writer #(
  parameter int BUFFER_SIZE       = 20,
  parameter int MEM_ADDRESS_WIDTH = 10,
  parameter int COUNT_WIDTH       = 16,
  parameter int MEM_WIDTH         = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_write,
  input  logic [MEM_ADDRESS_WIDTH-1:0]       i_address,
  input  logic [COUNT_WIDTH-1:0]             i_count,
  input  logic [BUFFER_SIZE*MEM_WIDTH-1:0]   i_buffer,
`ifdef DMA_WRITER_STRIDE_EN
  input  logic [MEM_ADDRESS_WIDTH-1:0]       i_stride,
`endif
  input  logic                               i_mem_ready,
  output logic [MEM_ADDRESS_WIDTH-1:0]       o_mem_addr,
  output logic [MEM_WIDTH-1:0]               o_mem_data,
  output logic                               o_mem_write,
  output logic                               o_busy,
  output logic                               o_done
);

  localparam int BUF_W = BUFFER_SIZE * MEM_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] BUF_CNT = COUNT_WIDTH'(BUFFER_SIZE);
  localparam logic [COUNT_WIDTH-1:0] ONE_C   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] ZERO_C  = {COUNT_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                         state_r, state_nxt_s;
  logic [COUNT_WIDTH-1:0]         idx_r, idx_nxt_s;
  logic [COUNT_WIDTH-1:0]         cnt_r, cnt_nxt_s;
  // Snapshot is kept as a shift register: the word for the next beat is
  // always at the bottom, so no wide read multiplexer is needed.
  logic [BUF_W-1:0]               snap_r, snap_nxt_s;
  logic [MEM_ADDRESS_WIDTH-1:0]   addr_nxt_s;
  logic [MEM_WIDTH-1:0]           data_nxt_s;
  logic                           write_nxt_s, busy_nxt_s, done_nxt_s;
  logic [COUNT_WIDTH-1:0]         cnt_in_s;
  logic                           start_s, beat_s, last_s;
  logic [MEM_ADDRESS_WIDTH-1:0]   step_s;

`ifdef DMA_WRITER_STRIDE_EN
  logic [MEM_ADDRESS_WIDTH-1:0]   stride_r, stride_nxt_s;
  assign step_s = stride_r;
`else
  assign step_s = MEM_ADDRESS_WIDTH'(1);
`endif

  assign start_s = (state_r == ST_IDLE) && i_write;
  assign beat_s  = o_mem_write && i_mem_ready;
  assign last_s  = (idx_r == (cnt_r - ONE_C));

  // Clamp the requested count to the buffer depth.
  always_comb begin
    if (i_count > BUF_CNT) begin
      cnt_in_s = BUF_CNT;
    end else begin
      cnt_in_s = i_count;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          if (cnt_in_s != ZERO_C) begin
            state_nxt_s = ST_WRITE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (beat_s && last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the datapath registers.
  always_comb begin
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    snap_nxt_s  = snap_r;
    addr_nxt_s  = o_mem_addr;
    data_nxt_s  = o_mem_data;
    write_nxt_s = o_mem_write;
    busy_nxt_s  = o_busy;
    done_nxt_s  = 1'b0;
`ifdef DMA_WRITER_STRIDE_EN
    stride_nxt_s = stride_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          idx_nxt_s  = ZERO_C;
          cnt_nxt_s  = cnt_in_s;
          snap_nxt_s = i_buffer >> MEM_WIDTH;
          addr_nxt_s = i_address;
          data_nxt_s = i_buffer[MEM_WIDTH-1:0];
`ifdef DMA_WRITER_STRIDE_EN
          stride_nxt_s = i_stride;
`endif
          if (cnt_in_s != ZERO_C) begin
            write_nxt_s = 1'b1;
            busy_nxt_s  = 1'b1;
          end else begin
            write_nxt_s = 1'b0;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end
        end else begin
          write_nxt_s = 1'b0;
          busy_nxt_s  = 1'b0;
        end
      end
      ST_WRITE: begin
        if (beat_s) begin
          if (last_s) begin
            write_nxt_s = 1'b0;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            // Present the next beat immediately: no bubble between beats.
            idx_nxt_s  = idx_r + ONE_C;
            addr_nxt_s = o_mem_addr + step_s;
            data_nxt_s = snap_r[MEM_WIDTH-1:0];
            snap_nxt_s = snap_r >> MEM_WIDTH;
          end
        end else begin
          // Stalled: hold the presented beat.
          write_nxt_s = 1'b1;
        end
      end
      ST_DONE: begin
        write_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        write_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r       <= ZERO_C;
      cnt_r       <= ZERO_C;
      snap_r      <= {BUF_W{1'b0}};
      o_mem_addr  <= {MEM_ADDRESS_WIDTH{1'b0}};
      o_mem_data  <= {MEM_WIDTH{1'b0}};
      o_mem_write <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
`ifdef DMA_WRITER_STRIDE_EN
      stride_r    <= {MEM_ADDRESS_WIDTH{1'b0}};
`endif
    end else begin
      idx_r       <= idx_nxt_s;
      cnt_r       <= cnt_nxt_s;
      snap_r      <= snap_nxt_s;
      o_mem_addr  <= addr_nxt_s;
      o_mem_data  <= data_nxt_s;
      o_mem_write <= write_nxt_s;
      o_busy      <= busy_nxt_s;
      o_done      <= done_nxt_s;
`ifdef DMA_WRITER_STRIDE_EN
      stride_r    <= stride_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_dma_writer.sv
// -----------------------------------------------------------------------------
// tb_dma_writer
//   Self-checking bench for dma_writer. Each task drives one scenario. It
//   compares the observed beat stream against a list built from the transfer
//   rules: min(count, 20) beats, beat k at (base + k*stride) mod 1024 carrying
//   buffer word k. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dma_writer;

  localparam int BS = 20;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int MW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_write = 1'b0;
  logic [AW-1:0]     i_address = '0;
  logic [CW-1:0]     i_count = '0;
  logic [BS*MW-1:0]  i_buffer = '0;
  logic [AW-1:0]     i_stride = 10'd1;
  logic              i_mem_ready = 1'b1;
  logic [AW-1:0]     o_mem_addr;
  logic [MW-1:0]     o_mem_data;
  logic              o_mem_write;
  logic              o_busy;
  logic              o_done;

  dma_writer dut (
    .clk(clk), .rst(rst), .i_write(i_write), .i_address(i_address),
    .i_count(i_count), .i_buffer(i_buffer),
`ifdef DMA_WRITER_STRIDE_EN
    .i_stride(i_stride),
`endif
    .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_write(o_mem_write), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [MW-1:0] words [BS];
  logic [AW-1:0] e_addr[$];
  logic [MW-1:0] e_data[$];
  logic [AW-1:0] b_addr[$];
  logic [MW-1:0] b_data[$];
  int            b_cyc[$];
  int            d_cyc[$];
  logic [AW-1:0] st_addr[$];
  logic [MW-1:0] st_data[$];
  int            busy_n, busy_first, busy_last;

  function automatic logic [BS*MW-1:0] pack_words();
    logic [BS*MW-1:0] v;
    for (int k = 0; k < BS; k++) v[k*MW +: MW] = words[k];
    return v;
  endfunction

  // Expected beat list from the transfer rules.
  task automatic model(input int base, input int count, input int stride);
    int n;
    e_addr.delete(); e_data.delete();
    n = (count > BS) ? BS : count;
    for (int k = 0; k < n; k++) begin
      e_addr.push_back(AW'((base + k * stride) % 1024));
      e_data.push_back(words[k]);
    end
  endtask

  // Present a start request; returns at #1 after the start edge (cycle 1).
  task automatic do_start(input int base, input int count, input int stride);
    @(posedge clk); #1;
    i_write   = 1'b1;
    i_address = AW'(base);
    i_count   = CW'(count);
    i_stride  = AW'(stride);
    i_buffer  = pack_words();
    @(posedge clk); #1;
  endtask

  // Record beats/done/busy per cycle. mode 0: ready=1, 1: random ready,
  // 2: ready low for 3 cycles while beat index 2 is presented.
  task automatic collect(input int hold, input int mode, input int ndone, input int budget);
    int stall = 0;
    bit fin = 1'b0;
    b_addr.delete(); b_data.delete(); b_cyc.delete(); d_cyc.delete();
    st_addr.delete(); st_data.delete();
    busy_n = 0; busy_first = -1; busy_last = -1;
    for (int c = 1; c <= budget && !fin; c++) begin
      i_write = (c < hold);
      if (mode == 1) i_mem_ready = ($urandom_range(0, 2) != 0);
      else if (mode == 2 && b_addr.size() == 2 && stall < 3) begin
        i_mem_ready = 1'b0; stall++;
      end else i_mem_ready = 1'b1;
      @(negedge clk);
      if (o_mem_write && i_mem_ready) begin
        b_addr.push_back(o_mem_addr); b_data.push_back(o_mem_data); b_cyc.push_back(c);
      end
      if (o_mem_write && !i_mem_ready) begin
        st_addr.push_back(o_mem_addr); st_data.push_back(o_mem_data);
      end
      if (o_busy) begin
        busy_n++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (o_done) d_cyc.push_back(c);
      if (d_cyc.size() == ndone) fin = 1'b1;
      @(posedge clk); #1;
    end
    i_write = 1'b0;
    i_mem_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o_mem_addr, o_mem_data, o_mem_write, o_busy, o_done} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h data=%h wr=%b busy=%b done=%b, required all 0",
               o_mem_addr, o_mem_data, o_mem_write, o_busy, o_done);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_mem_write !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: wr=%b busy=%b done=%b, required 0", o_mem_write, o_busy, o_done);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < BS; k++) words[k] = MW'(16'hA000 + k);
    model(16'h010, 4, 1);
    do_start(16'h010, 4, 1);
    collect(1, 0, 1, 60);
    n_checks++;
    if (b_addr.size() != 4) begin
      n_fail++; $display("FAIL basic_beats: got %0d beats, required 4", b_addr.size());
    end
    for (int k = 0; k < 4 && k < b_addr.size(); k++) begin
      n_checks++;
      if (b_addr[k] !== e_addr[k] || b_data[k] !== e_data[k] || b_cyc[k] != k + 1) begin
        n_fail++;
        $display("FAIL basic_beat[%0d]: got %h/%h @%0d, required %h/%h @%0d",
                 k, b_addr[k], b_data[k], b_cyc[k], e_addr[k], e_data[k], k + 1);
      end
    end
    n_checks++;
    if (d_cyc.size() != 1 || d_cyc[0] != 5) begin
      n_fail++; $display("FAIL basic_done: got %0d pulses (first @%0d), required 1 @5",
                         d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1);
    end
    n_checks++;
    if (busy_n != 4 || busy_first != 1 || busy_last != 4) begin
      n_fail++; $display("FAIL basic_busy: got %0d cycles %0d..%0d, required 4 cycles 1..4",
                         busy_n, busy_first, busy_last);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < BS; k++) words[k] = MW'(16'hA000 + k);
    model(16'h010, 4, 1);
    do_start(16'h010, 4, 1);
    collect(1, 2, 1, 60);
    n_checks++;
    if (b_addr.size() != 4) begin
      n_fail++; $display("FAIL bp_beats: got %0d beats, required 4", b_addr.size());
    end
    for (int k = 0; k < 4 && k < b_addr.size(); k++) begin
      n_checks++;
      if (b_addr[k] !== e_addr[k] || b_data[k] !== e_data[k]) begin
        n_fail++; $display("FAIL bp_beat[%0d]: got %h/%h, required %h/%h",
                           k, b_addr[k], b_data[k], e_addr[k], e_data[k]);
      end
    end
    n_checks++;
    if (st_addr.size() != 3) begin
      n_fail++; $display("FAIL bp_stall_cycles: got %0d, required 3", st_addr.size());
    end
    for (int k = 0; k < st_addr.size(); k++) begin
      n_checks++;
      if (st_addr[k] !== 10'h012 || st_data[k] !== 16'hA002) begin
        n_fail++; $display("FAIL bp_stall_hold[%0d]: got %h/%h, required 012/a002",
                           k, st_addr[k], st_data[k]);
      end
    end
    n_checks++;
    if (d_cyc.size() != 1 || d_cyc[0] != 8 || busy_n != 7) begin
      n_fail++; $display("FAIL bp_done: got done@%0d busy=%0d, required done@8 busy=7",
                         (d_cyc.size() > 0) ? d_cyc[0] : -1, busy_n);
    end
  endtask

  task automatic test_clamp_zero();
    for (int k = 0; k < BS; k++) words[k] = MW'($urandom);
    model(16'h100, 25, 1);
    do_start(16'h100, 25, 1);
    collect(1, 0, 1, 80);
    n_checks++;
    if (b_addr.size() != 20 || d_cyc.size() != 1 || d_cyc[0] != 21) begin
      n_fail++; $display("FAIL clamp_count: got %0d beats done@%0d, required 20 beats done@21",
                         b_addr.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1);
    end
    for (int k = 0; k < 20 && k < b_addr.size(); k++) begin
      n_checks++;
      if (b_addr[k] !== e_addr[k] || b_data[k] !== e_data[k]) begin
        n_fail++; $display("FAIL clamp_beat[%0d]: got %h/%h, required %h/%h",
                           k, b_addr[k], b_data[k], e_addr[k], e_data[k]);
      end
    end
    do_start(16'h200, 0, 1);
    collect(1, 0, 1, 20);
    n_checks++;
    if (b_addr.size() != 0 || d_cyc.size() != 1 || d_cyc[0] != 1 || busy_n != 0) begin
      n_fail++; $display("FAIL zero_count: got %0d beats done@%0d busy=%0d, required 0 beats done@1 busy=0",
                         b_addr.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1, busy_n);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < BS; k++) words[k] = MW'($urandom);
    do_start(16'h3FE, 4, 1);
    collect(1, 0, 1, 40);
    n_checks++;
    if (b_addr.size() != 4) begin
      n_fail++; $display("FAIL wrap_beats: got %0d, required 4", b_addr.size());
    end else begin
      n_checks++;
      if (b_addr[0] !== 10'h3FE || b_addr[1] !== 10'h3FF || b_addr[2] !== 10'h000 || b_addr[3] !== 10'h001) begin
        n_fail++; $display("FAIL wrap_addr: got %h %h %h %h, required 3fe 3ff 000 001",
                           b_addr[0], b_addr[1], b_addr[2], b_addr[3]);
      end
    end
  endtask

  task automatic test_snapshot_reset();
    for (int k = 0; k < BS; k++) words[k] = MW'($urandom);
    model(16'h050, 10, 1);
    do_start(16'h050, 10, 1);
    // Inputs change right after the start edge; the transfer must not see it.
    i_write = 1'b0; i_buffer = ~pack_words(); i_address = 10'h123; i_count = 16'd3;
    b_addr.delete(); b_data.delete();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (o_mem_write) begin b_addr.push_back(o_mem_addr); b_data.push_back(o_mem_data); end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= b_addr.size() || b_addr[k] !== e_addr[k] || b_data[k] !== e_data[k]) begin
        n_fail++; $display("FAIL snap_beat[%0d]: got %h/%h, required %h/%h", k,
                           (k < b_addr.size()) ? b_addr[k] : 10'h0, (k < b_data.size()) ? b_data[k] : 16'h0,
                           e_addr[k], e_data[k]);
      end
    end
    n_checks++;
    if (o_mem_write !== 1'b1 || o_mem_addr !== e_addr[3] || o_mem_data !== e_data[3]) begin
      n_fail++; $display("FAIL snap_beat3: got wr=%b %h/%h, required 1 %h/%h",
                         o_mem_write, o_mem_addr, o_mem_data, e_addr[3], e_data[3]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({o_mem_addr, o_mem_data, o_mem_write, o_busy, o_done} !== 29'd0) begin
      n_fail++; $display("FAIL async_reset: got addr=%h data=%h wr=%b busy=%b done=%b, required all 0",
                         o_mem_addr, o_mem_data, o_mem_write, o_busy, o_done);
    end
    @(posedge clk); @(negedge clk); rst = 1'b0;
    begin
      int act = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (o_mem_write || o_busy || o_done) act++;
      end
      n_checks++;
      if (act != 0) begin
        n_fail++; $display("FAIL post_reset_quiet: got %0d active cycles, required 0", act);
      end
    end
    for (int k = 0; k < BS; k++) words[k] = MW'($urandom);
    model(16'h200, 2, 1);
    do_start(16'h200, 2, 1);
    collect(1, 0, 1, 30);
    n_checks++;
    if (b_addr.size() != 2 || b_addr[0] !== e_addr[0] || b_data[1] !== e_data[1] || d_cyc.size() != 1) begin
      n_fail++; $display("FAIL restart_after_reset: got %0d beats %0d dones, required 2 beats 1 done",
                         b_addr.size(), d_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < BS; k++) words[k] = MW'($urandom);
    do_start(16'h020, 2, 1);
    i_address = 10'h040;
    collect(5, 0, 2, 40);
    n_checks++;
    if (b_addr.size() != 4 || d_cyc.size() != 2) begin
      n_fail++; $display("FAIL b2b_counts: got %0d beats %0d dones, required 4 and 2", b_addr.size(), d_cyc.size());
    end else begin
      n_checks++;
      if (b_addr[0] !== 10'h020 || b_addr[1] !== 10'h021 || b_addr[2] !== 10'h040 || b_addr[3] !== 10'h041 ||
          b_data[2] !== words[0] || b_data[3] !== words[1] ||
          b_cyc[2] != 5 || b_cyc[3] != 6 || d_cyc[0] != 3 || d_cyc[1] != 7) begin
        n_fail++; $display("FAIL b2b_stream: got %h@%0d %h@%0d %h@%0d %h@%0d done@%0d,%0d, required 020@1 021@2 040@5 041@6 done@3,7",
                           b_addr[0], b_cyc[0], b_addr[1], b_cyc[1], b_addr[2], b_cyc[2], b_addr[3], b_cyc[3], d_cyc[0], d_cyc[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int base, cnt, stride, exp_done;
      for (int k = 0; k < BS; k++) words[k] = MW'($urandom);
      base = $urandom_range(0, 1023);
      cnt  = $urandom_range(0, 25);
`ifdef DMA_WRITER_STRIDE_EN
      stride = $urandom_range(0, 1023);
`else
      stride = 1;
`endif
      model(base, cnt, stride);
      do_start(base, cnt, stride);
      collect(1, 1, 1, 400);
      n_checks++;
      if (b_addr.size() != e_addr.size() || d_cyc.size() != 1) begin
        n_fail++; $display("FAIL rand%0d_counts: got %0d beats %0d dones, required %0d beats 1 done",
                           it, b_addr.size(), d_cyc.size(), e_addr.size());
      end else begin
        for (int k = 0; k < e_addr.size(); k++) begin
          n_checks++;
          if (b_addr[k] !== e_addr[k] || b_data[k] !== e_data[k]) begin
            n_fail++; $display("FAIL rand%0d_beat[%0d]: got %h/%h, required %h/%h",
                               it, k, b_addr[k], b_data[k], e_addr[k], e_data[k]);
          end
        end
        exp_done = (b_cyc.size() == 0) ? 1 : b_cyc[b_cyc.size() - 1] + 1;
        n_checks++;
        if (d_cyc[0] != exp_done || busy_n != exp_done - 1) begin
          n_fail++; $display("FAIL rand%0d_done: got done@%0d busy=%0d, required done@%0d busy=%0d",
                             it, d_cyc[0], busy_n, exp_done, exp_done - 1);
        end
      end
    end
  endtask

`ifdef DMA_WRITER_STRIDE_EN
  task automatic test_stride();
    for (int k = 0; k < BS; k++) words[k] = MW'($urandom);
    do_start(16'h100, 3, 3);
    collect(1, 0, 1, 30);
    n_checks++;
    if (b_addr.size() != 3 || b_addr[0] !== 10'h100 || b_addr[1] !== 10'h103 || b_addr[2] !== 10'h106) begin
      n_fail++; $display("FAIL stride3: got %0d beats, required 3 at 100 103 106", b_addr.size());
    end
    do_start(16'h0AA, 3, 0);
    collect(1, 0, 1, 30);
    n_checks++;
    if (b_addr.size() != 3 || b_addr[0] !== 10'h0AA || b_addr[1] !== 10'h0AA || b_addr[2] !== 10'h0AA) begin
      n_fail++; $display("FAIL stride0: got %0d beats, required 3 at 0aa", b_addr.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clamp_zero();
    test_wrap();
    test_snapshot_reset();
    test_back_to_back();
`ifdef DMA_WRITER_STRIDE_EN
    test_stride();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_writer.md
Name: dma_writer

Overview:
- Write-direction DMA for the fully-connected datapath: takes a parallel result buffer (e.g. FC layer outputs) and writes it word-by-word into memory at consecutive addresses.
- It is the counterpart of the read DMA that fills input buffers from memory.
- Sits between the FC output registers and the shared data memory write port.
- Uses a valid/ready write handshake so the memory side can stall it.

Parameters:
- BUFFER_SIZE, 20, number of words in the source buffer.
- MEM_ADDRESS_WIDTH, 10, memory address width.
- COUNT_WIDTH, 16, width of the transfer count.
- MEM_WIDTH, 16, memory word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_write  in  1  start request, sampled on rising clk edge while idle.
- i_address  in  MEM_ADDRESS_WIDTH  base memory address of the transfer.
- i_count  in  COUNT_WIDTH  number of words to write.
- i_buffer  in  BUFFER_SIZE*MEM_WIDTH  flattened source buffer; word k = bits [k*MEM_WIDTH +: MEM_WIDTH].
- i_mem_ready  in  1  memory accepts the current write beat.
- o_mem_addr  out  MEM_ADDRESS_WIDTH  write address.
- o_mem_data  out  MEM_WIDTH  write data.
- o_mem_write  out  1  write beat valid.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, WRITE, DONE. All outputs are registered.
- Reset (async, rst=1), regardless of clk:
  - state goes to IDLE;
  - o_mem_addr, o_mem_data, o_mem_write, o_busy and o_done all go to 0;
  - internal index and count clear.
  - Reset mid-transfer aborts immediately; no further beats are issued after rst deasserts.
- IDLE:
  - At a rising edge with i_write=1:
    - latch base = i_address;
    - latch cnt = min(i_count, BUFFER_SIZE);
    - snapshot all of i_buffer into an internal copy;
    - set idx = 0.
  - If cnt > 0: go to WRITE and set o_busy=1.
  - If cnt = 0: go to DONE with no beats issued.
  - After the start edge, i_buffer, i_address and i_count may change freely.
- WRITE:
  - o_mem_write=1, o_mem_addr = base + idx (truncated to MEM_ADDRESS_WIDTH, so addresses wrap modulo 2^MEM_ADDRESS_WIDTH), o_mem_data = snapshot[idx].
  - A beat completes on a rising edge where o_mem_write=1 and i_mem_ready=1.
  - While i_mem_ready=0, addr/data/o_mem_write hold stable.
  - On a completed beat:
    - if idx = cnt-1, go to DONE and drive o_mem_write=0;
    - otherwise idx increments and the next beat is presented in the following cycle, with no bubble.
- DONE:
  - Lasts exactly one cycle: o_done=1, o_busy=0, o_mem_write=0.
  - Then return to IDLE with o_done=0.
- Latency: start accepted at edge N, first beat visible in cycle N+1. With i_mem_ready held at 1, cnt beats occupy cycles N+1..N+cnt and o_done is high in cycle N+cnt+1.
- i_write while in WRITE or DONE is ignored; requests are not queued.
- i_write held high across DONE→IDLE starts a new transfer on the first IDLE edge.
- A simultaneous rst and i_write: reset wins.
- The index and count compare use COUNT_WIDTH-bit unsigned arithmetic.

Optional Feature:
- Macro: DMA_WRITER_STRIDE_EN.
- Defined:
  - adds port i_stride (input, MEM_ADDRESS_WIDTH bits), latched at start with the other inputs;
  - beat k address = base + k*i_stride, modulo 2^MEM_ADDRESS_WIDTH;
  - implemented as an accumulating address register, not a multiplier;
  - stride 0 writes every beat to base.
- Not defined: port absent; stride is fixed at 1 (behaviour as above).

Test Plan:
- Basic write:
  - Stimulus: i_address=0x010, i_count=4, buffer words 0xA000..0xA003, i_mem_ready=1.
  - Required: exactly 4 beats at addr 0x010..0x013 with matching data in consecutive cycles; o_done pulses one cycle later; o_busy high exactly during the beats.
- Back-pressure:
  - Stimulus: same as basic write, but i_mem_ready low for 3 cycles on beat 2.
  - Required: beat 2 addr 0x012 / data 0xA002 held stable for the stall; no beat lost or duplicated; o_done is delayed by 3 cycles.
- Clamp and zero:
  - Stimulus: i_count=25 (BUFFER_SIZE=20), then i_count=0.
  - Required: first run writes 20 beats; second run issues no beat and o_done pulses in cycle N+1.
- Wrap:
  - Stimulus: i_address=0x3FE, i_count=4.
  - Required: addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Snapshot and reset:
  - Stimulus: change i_buffer and i_address right after start; then assert rst asynchronously (between clock edges) during beat 3 of 10.
  - Required: written data and addresses reflect the values at start; on reset all outputs are 0 immediately; no beats after release; a new i_write then works normally.
- Stride (with DMA_WRITER_STRIDE_EN):
  - Stimulus: base 0x100, stride 3, count 3.
  - Required: addresses 0x100, 0x103, 0x106.
